// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, fixed 3x3 kernel, bias, FSM states and
// layer-memory select encodings for the conv_pool_engine block.
// No ports. The CONV_POOL_EN macro is consumed by conv_pool_engine, not here.
package conv_pkg;

  localparam int DATA_W = 20;
  localparam int FRAC_W = 16;
  localparam int IMG_W  = 64;
  localparam int ADDR_W = 12;
  localparam int ACC_W  = 44;
  localparam int NTAP   = 9;

  // Kernel, row-major: K0[i*3+j] multiplies x[r+i-1][c+j-1].
  localparam logic signed [DATA_W-1:0] K0 [NTAP] = '{
    20'sh0A89E, 20'sh092D5, 20'sh06D43,
    20'sh01004, 20'shF8F71, 20'shF6E54,
    20'shFA6D7, 20'shFC834, 20'shFAC19
  };

  localparam logic signed [DATA_W-1:0] BIAS0 = 20'sh01310;

  typedef enum logic [2:0] {
    IDLE,
    CONV_RD,
    CONV_WR,
    POOL_RD,
    POOL_WR,
    DONE
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0   = 3'b001;
  localparam logic [2:0] SEL_L1   = 3'b011;

endpackage

// File: rtl/conv_pool_engine_mac.sv
// conv_mac: signed multiply-accumulate with round-half-up, bias add and ReLU.
// Latency: one cycle per accumulated tap; result is combinational from the accumulator.
// Backpressure: none; the caller gates accumulation with en and restarts with clr.
// Ports: clk, reset (sync, active high), clr (zero the accumulator), en (add
// pixel*coef), pixel/coef (signed Q4.16), result (biased, rectified Q4.16).
module conv_mac
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] coef,
  output logic        [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    rnd;
  logic signed [DATA_W-1:0]   biased;

  assign prod = pixel * coef;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  // Sum carries 32 fraction bits: add half an LSB of the Q4.16 result, then
  // keep bits [35:16]; integer overflow wraps into the 4 integer bits.
  assign rnd    = acc + ACC_W'(1 << (FRAC_W - 1));
  assign biased = DATA_W'(rnd >>> FRAC_W) + BIAS0;
  assign result = biased[DATA_W-1] ? '0 : biased;

endmodule

// File: rtl/conv_pool_engine.sv
// conv_pool_engine: 3x3 zero-padded conv + bias + ReLU over a 64x64 image into
// layer 0, then 2x2/2 max-pool of layer 0 into layer 1 (pooling only when
// CONV_POOL_EN is defined; otherwise the run ends after the layer-0 pass).
// Latency: 11 cycles per layer-0 pixel, 6 cycles per layer-1 pixel.
// Backpressure: none; memories answer every read on the next edge.
// Ports: ready starts a run from IDLE; busy spans the run; iaddr/idata image
// ROM; crd/caddr_rd/cdata_rd layer reads; cwr/caddr_wr/cdata_wr layer writes;
// csel selects layer 0 (001) or layer 1 (011). All outputs are registered.
module conv_pool_engine
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);

  state_t              state, state_n;
  logic [3:0]          tap, tap_n;      // conv tap 0..9 / pool read 0..4
  logic [3:0]          kt, kt_n;        // tap whose read is in flight
  logic                vld, vld_n;      // in-flight tap is inside the image
  logic [ADDR_W-1:0]   pix, pix_n;      // output pixel index of current layer
  logic [DATA_W-1:0]   mx, mx_n;        // running pool maximum
  logic                busy_n, crd_n, cwr_n;
  logic [ADDR_W-1:0]   iaddr_n, caddr_rd_n, caddr_wr_n;
  logic [DATA_W-1:0]   cdata_wr_n;
  logic [2:0]          csel_n;
  logic                mac_clr, mac_en;
  logic [DATA_W-1:0]   mac_res;
  logic [1:0]          ti, tj;
  logic [7:0]          row_t, col_t;
  logic                inb;

  conv_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (mac_clr),
    .en     (mac_en),
    .pixel  (idata),
    .coef   (K0[kt]),
    .result (mac_res)
  );

  // Neighbour coordinates for the current tap; -1 wraps to 255 so a single
  // unsigned compare catches both edges.
  assign ti    = 2'(tap / 4'd3);
  assign tj    = 2'(tap % 4'd3);
  assign row_t = {2'b00, pix[11:6]} + {6'b0, ti} - 8'd1;
  assign col_t = {2'b00, pix[5:0]}  + {6'b0, tj} - 8'd1;
  assign inb   = (row_t < 8'(IMG_W)) && (col_t < 8'(IMG_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tap      <= '0;
      kt       <= '0;
      vld      <= 1'b0;
      pix      <= '0;
      mx       <= '0;
      busy     <= 1'b0;
      iaddr    <= '0;
      crd      <= 1'b0;
      caddr_rd <= '0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= SEL_NONE;
    end else begin
      state    <= state_n;
      tap      <= tap_n;
      kt       <= kt_n;
      vld      <= vld_n;
      pix      <= pix_n;
      mx       <= mx_n;
      busy     <= busy_n;
      iaddr    <= iaddr_n;
      crd      <= crd_n;
      caddr_rd <= caddr_rd_n;
      cwr      <= cwr_n;
      caddr_wr <= caddr_wr_n;
      cdata_wr <= cdata_wr_n;
      csel     <= csel_n;
    end
  end

  always_comb begin
    state_n    = state;
    tap_n      = tap;
    kt_n       = kt;
    vld_n      = vld;
    pix_n      = pix;
    mx_n       = mx;
    busy_n     = busy;
    iaddr_n    = iaddr;
    crd_n      = 1'b0;
    caddr_rd_n = caddr_rd;
    cwr_n      = 1'b0;
    caddr_wr_n = caddr_wr;
    cdata_wr_n = cdata_wr;
    csel_n     = csel;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;

    case (state)
      IDLE: begin
        mac_clr = 1'b1;
        if (ready) begin
          state_n = CONV_RD;
          busy_n  = 1'b1;
          tap_n   = '0;
          pix_n   = '0;
        end
      end

      // Issue tap t while consuming tap t-1; padded taps leave iaddr alone.
      CONV_RD: begin
        if (tap < 4'd9) begin
          if (inb) iaddr_n = {row_t[5:0], col_t[5:0]};
          vld_n = inb;
          kt_n  = tap;
        end
        mac_en = (tap != 4'd0) && vld;
        tap_n  = tap + 4'd1;
        if (tap == 4'd9) state_n = CONV_WR;
      end

      CONV_WR: begin
        cwr_n      = 1'b1;
        csel_n     = SEL_L0;
        caddr_wr_n = pix;
        cdata_wr_n = mac_res;
        mac_clr    = 1'b1;
        tap_n      = '0;
        if (pix == ADDR_W'(IMG_W * IMG_W - 1)) begin
          pix_n = '0;
`ifdef CONV_POOL_EN
          state_n = POOL_RD;
`else
          state_n = DONE;
`endif
        end else begin
          pix_n   = pix + 12'd1;
          state_n = CONV_RD;
        end
      end

      // Without CONV_POOL_EN nothing transitions into the pool states, so
      // they are unreachable and trimmed away.
      POOL_RD: begin
        if (tap < 4'd4) begin
          crd_n      = 1'b1;
          csel_n     = SEL_L0;
          caddr_rd_n = {pix[9:5], tap[1], pix[4:0], tap[0]};
        end
        if (tap != 4'd0) begin
          if (tap == 4'd1 || $signed(cdata_rd) > $signed(mx)) mx_n = cdata_rd;
        end
        tap_n = tap + 4'd1;
        if (tap == 4'd4) state_n = POOL_WR;
      end

      POOL_WR: begin
        cwr_n      = 1'b1;
        csel_n     = SEL_L1;
        caddr_wr_n = {2'b00, pix[9:0]};
        cdata_wr_n = mx;
        tap_n      = '0;
        if (pix[9:0] == 10'(IMG_W * IMG_W / 4 - 1)) begin
          state_n = DONE;
        end else begin
          pix_n   = pix + 12'd1;
          state_n = POOL_RD;
        end
      end

      DONE: begin
        busy_n  = 1'b0;
        csel_n  = SEL_NONE;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Bench for conv_pool_engine: image ROM and layer memories modelled as arrays,
// expected layers computed from the arithmetic rules of the algorithm.
module tb_conv_pool_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic        busy, crd, cwr;
  logic [11:0] iaddr, caddr_rd, caddr_wr;
  logic [19:0] idata, cdata_rd, cdata_wr;
  logic [2:0]  csel;

  conv_pool_engine dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr),
    .idata(idata), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] SENT = 20'hABCDE;
`ifdef CONV_POOL_EN
  localparam logic [2:0]  LAST_SEL  = 3'b011;
  localparam logic [11:0] LAST_ADDR = 12'd1023;
  localparam int          BOUND     = 4096 * 12 + 1024 * 6 + 4;
`else
  localparam logic [2:0]  LAST_SEL  = 3'b001;
  localparam logic [11:0] LAST_ADDR = 12'd4095;
  localparam int          BOUND     = 4096 * 12 + 4;
`endif

  localparam int          DA [11] = '{715, 714, 651, 650, 585, 65, 0, 1, 64, 425, 1300};
  localparam logic [19:0] DV [11] = '{20'h0BBAE, 20'h0A5E5, 20'h02314, 20'h00000, 20'h00000,
                                      20'h0BBAE, 20'h00000, 20'h02314, 20'h0A5E5, 20'h01311,
                                      20'h01310};

  logic [19:0] kt [9] = '{20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
                          20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19};

  logic [19:0] img [4096];
  logic [19:0] l0 [4096];
  logic [19:0] l1 [1024];
  logic [19:0] exp_l0 [4096];
  logic [19:0] exp_l1 [1024];

  int total = 0;
  int bad = 0;

  assign idata    = img[iaddr];
  assign cdata_rd = crd ? l0[caddr_rd] : 20'h0;

  // Memory write port plus protocol monitor.
  logic clr_mem = 1'b0;
  logic cwr_q;
  int   n_l0, n_l1, sel_err, ovl_err, pulse_err, l1_seen, busy_cyc;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int a = 0; a < 4096; a++) l0[a] <= SENT;
      for (int a = 0; a < 1024; a++) l1[a] <= SENT;
      n_l0 <= 0; n_l1 <= 0; sel_err <= 0; ovl_err <= 0;
      pulse_err <= 0; l1_seen <= 0; busy_cyc <= 0; cwr_q <= 1'b0;
    end else begin
      cwr_q <= cwr;
      if (busy) busy_cyc <= busy_cyc + 1;
      if (crd && cwr) ovl_err <= ovl_err + 1;
      if (cwr && cwr_q) pulse_err <= pulse_err + 1;
      if (crd && csel != 3'b001) sel_err <= sel_err + 1;
      if (csel == 3'b011) l1_seen <= l1_seen + 1;
      if (cwr) begin
        case (csel)
          3'b001: begin l0[caddr_wr] <= cdata_wr; n_l0 <= n_l0 + 1; end
          3'b011: begin l1[caddr_wr[9:0]] <= cdata_wr; n_l1 <= n_l1 + 1; end
          default: sel_err <= sel_err + 1;
        endcase
      end
    end
  end

  function automatic longint sx(input logic [19:0] x);
    return {{44{x[19]}}, x};
  endfunction

  // Directed patterns in the top rows, random pixels in rows 32..63.
  task automatic build_image();
    for (int a = 0; a < 4096; a++) img[a] = 20'h0;
    img[10 * 64 + 10] = 20'h10000;
    img[0]            = 20'h10000;
    img[5 * 64 + 40]  = 20'h00001;
    for (int a = 32 * 64; a < 4096; a++) img[a] = 20'($urandom);
  endtask

  task automatic build_model();
    longint s, v, m;
    int rr, cc;
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            rr = r + i - 1;
            cc = c + j - 1;
            if (rr >= 0 && rr < 64 && cc >= 0 && cc < 64)
              s += sx(kt[i * 3 + j]) * sx(img[rr * 64 + cc]);
          end
        end
        v = ((s + 32768) >>> 16) & 64'hFFFFF;
        v = (v + 64'h01310) & 64'hFFFFF;
        if (v >= 64'h80000) v = 0;
        exp_l0[r * 64 + c] = v[19:0];
      end
    end
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        m = sx(exp_l0[(2 * r) * 64 + 2 * c]);
        if (sx(exp_l0[(2 * r) * 64 + 2 * c + 1]) > m) m = sx(exp_l0[(2 * r) * 64 + 2 * c + 1]);
        if (sx(exp_l0[(2 * r + 1) * 64 + 2 * c]) > m) m = sx(exp_l0[(2 * r + 1) * 64 + 2 * c]);
        if (sx(exp_l0[(2 * r + 1) * 64 + 2 * c + 1]) > m) m = sx(exp_l0[(2 * r + 1) * 64 + 2 * c + 1]);
        exp_l1[r * 32 + c] = m[19:0];
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total += 9;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    if (crd !== 1'b0) begin bad++; $display("FAIL reset_crd got=%0b want=0", crd); end
    if (cwr !== 1'b0) begin bad++; $display("FAIL reset_cwr got=%0b want=0", cwr); end
    if (iaddr !== 12'h0) begin bad++; $display("FAIL reset_iaddr got=%h want=000", iaddr); end
    if (caddr_rd !== 12'h0) begin bad++; $display("FAIL reset_caddr_rd got=%h want=000", caddr_rd); end
    if (caddr_wr !== 12'h0) begin bad++; $display("FAIL reset_caddr_wr got=%h want=000", caddr_wr); end
    if (cdata_wr !== 20'h0) begin bad++; $display("FAIL reset_cdata_wr got=%h want=00000", cdata_wr); end
    if (csel !== 3'b000) begin bad++; $display("FAIL reset_csel got=%b want=000", csel); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b want=0", busy); end
  endtask

  task automatic test_abort();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0b want=1", busy); end
    repeat (300) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
    if (cwr !== 1'b0) begin bad++; $display("FAIL abort_cwr got=%0b want=0", cwr); end
    if (crd !== 1'b0) begin bad++; $display("FAIL abort_crd got=%0b want=0", crd); end
    if (csel !== 3'b000) begin bad++; $display("FAIL abort_csel got=%b want=000", csel); end
    repeat (3) @(negedge clk);
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_stay_idle got=%0b want=0", busy); end
  endtask

  task automatic test_full_run();
    int waited;
    clr_mem = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rerun_busy got=%0b want=1", busy); end
    waited = 0;
    while (!(cwr && csel == LAST_SEL && caddr_wr == LAST_ADDR) && waited < 70000) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited >= 70000) begin
      bad++;
      $display("FAIL last_write_timeout waited=%0d want<70000", waited);
    end else begin
      total += 3;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_at_last_write got=%0b want=1", busy); end
      @(negedge clk);
      if (busy !== 1'b0) begin bad++; $display("FAIL done_busy got=%0b want=0", busy); end
      if (csel !== 3'b000) begin bad++; $display("FAIL done_csel got=%b want=000", csel); end
    end
    total++;
    if (busy_cyc > BOUND) begin bad++; $display("FAIL latency busy_cycles=%0d want<=%0d", busy_cyc, BOUND); end
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL no_restart got=%0b want=0", busy); end
  endtask

  task automatic test_directed_l0();
    for (int n = 0; n < 11; n++) begin
      total++;
      if (l0[DA[n]] !== DV[n]) begin
        bad++;
        $display("FAIL directed_l0[%0d] got=%h want=%h", DA[n], l0[DA[n]], DV[n]);
      end
    end
  endtask

  task automatic test_model_l0();
    for (int a = 0; a < 4096; a++) begin
      total++;
      if (l0[a] !== exp_l0[a]) begin
        bad++;
        $display("FAIL model_l0[%0d] got=%h want=%h", a, l0[a], exp_l0[a]);
      end
    end
  endtask

  task automatic test_pool();
`ifdef CONV_POOL_EN
    total += 4;
    if (l1[165] !== 20'h0BBAE) begin bad++; $display("FAIL pool_l1[165] got=%h want=0BBAE", l1[165]); end
    if (l1[0] !== 20'h0BBAE) begin bad++; $display("FAIL pool_l1[0] got=%h want=0BBAE", l1[0]); end
    if (l1[116] !== 20'h01311) begin bad++; $display("FAIL pool_l1[116] got=%h want=01311", l1[116]); end
    if (l1[330] !== 20'h01310) begin bad++; $display("FAIL pool_l1[330] got=%h want=01310", l1[330]); end
    for (int a = 0; a < 1024; a++) begin
      total++;
      if (l1[a] !== exp_l1[a]) begin
        bad++;
        $display("FAIL model_l1[%0d] got=%h want=%h", a, l1[a], exp_l1[a]);
      end
    end
`else
    total++;
    if (l1[0] !== SENT) begin bad++; $display("FAIL l1_untouched got=%h want=%h", l1[0], SENT); end
`endif
  endtask

  task automatic test_protocol();
    total += 5;
    if (ovl_err !== 0) begin bad++; $display("FAIL crd_cwr_overlap count=%0d want=0", ovl_err); end
    if (pulse_err !== 0) begin bad++; $display("FAIL cwr_pulse count=%0d want=0", pulse_err); end
    if (sel_err !== 0) begin bad++; $display("FAIL csel_usage count=%0d want=0", sel_err); end
    if (n_l0 !== 4096) begin bad++; $display("FAIL l0_writes count=%0d want=4096", n_l0); end
`ifdef CONV_POOL_EN
    if (n_l1 !== 1024) begin bad++; $display("FAIL l1_writes count=%0d want=1024", n_l1); end
`else
    if (l1_seen !== 0) begin bad++; $display("FAIL csel_011_cycles count=%0d want=0", l1_seen); end
`endif
  endtask

  initial begin
    build_image();
    build_model();
    test_reset();
    test_abort();
    test_full_run();
    test_directed_l0();
    test_model_l0();
    test_pool();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
